mem_wb_stage: RTL and testbench

- Pipeline register and writeback-select logic between the MEM stage and the register file in the 5-stage MIPS pipeline.
- Captures MEM-stage results on the rising edge and resolves the destination register and write data (ALU, load, or jal link).
- Drives the register file's write port: regWrite, writeReg, writeData.
- Supports stall and flush, and keeps a retired-instruction counter for the testbench and debug.

---
 rtl/mem_wb_stage.sv | 81 ++++++++
 tb/tb_mem_wb_stage.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures MEM results, resolves the writeback
// destination and data, and counts retired instructions.
module mem_wb_stage #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned LINK_REG       = 31
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      memValid,
  input  logic                      memRegWrite,
  input  logic                      memMemToReg,
  input  logic                      memLink,
  input  logic [REG_ADDR_WIDTH-1:0] memWriteReg,
  input  logic [DATA_WIDTH-1:0]     memAluResult,
  input  logic [DATA_WIDTH-1:0]     memReadData,
  input  logic [DATA_WIDTH-1:0]     memPcPlus4,
  output logic                      wbValid,
  output logic                      wbRegWrite,
  output logic [REG_ADDR_WIDTH-1:0] wbWriteReg,
  output logic [DATA_WIDTH-1:0]     wbWriteData,
  output logic [31:0]               retireCount
);

  localparam int unsigned CNT_WIDTH = 32;
  localparam logic [REG_ADDR_WIDTH-1:0] LINK_IDX = REG_ADDR_WIDTH'(LINK_REG);

  logic [REG_ADDR_WIDTH-1:0] w_dest;
  logic [DATA_WIDTH-1:0]     w_wdata;
  logic                      w_reg_we;

  logic                      r_valid;
  logic                      r_reg_write;
  logic [REG_ADDR_WIDTH-1:0] r_write_reg;
  logic [DATA_WIDTH-1:0]     r_write_data;
  logic [CNT_WIDTH-1:0]      r_retire_count;

  // Writeback select: link beats load, load beats ALU; $0 is never written.
  always_comb begin
    w_dest   = memLink ? LINK_IDX : memWriteReg;
    w_wdata  = memAluResult;
    if (memLink) begin
      w_wdata = memPcPlus4;
    end else if (memMemToReg) begin
      w_wdata = memReadData;
    end
    w_reg_we = memValid & (memRegWrite | memLink) & (w_dest != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid        <= 1'b0;
      r_reg_write    <= 1'b0;
      r_write_reg    <= '0;
      r_write_data   <= '0;
      r_retire_count <= '0;
    end else if (flush) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else if (!stall) begin
      r_valid      <= memValid;
      r_reg_write  <= w_reg_we;
      r_write_reg  <= w_dest;
      r_write_data <= w_wdata;
      if (memValid) begin
        r_retire_count <= r_retire_count + CNT_WIDTH'(1);
      end
    end
  end

  assign wbValid     = r_valid;
  assign wbRegWrite  = r_reg_write;
  assign wbWriteReg  = r_write_reg;
  assign wbWriteData = r_write_data;
  assign retireCount = r_retire_count;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed cases with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_mem_wb_stage;

  logic        clk;
  logic        reset, stall, flush;
  logic        memValid, memRegWrite, memMemToReg, memLink;
  logic [4:0]  memWriteReg;
  logic [31:0] memAluResult, memReadData, memPcPlus4;
  logic        wbValid, wbRegWrite;
  logic [4:0]  wbWriteReg;
  logic [31:0] wbWriteData, retireCount;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;
  bit preload = 0;

  // behavioural model of the WB-side state
  logic        m_valid, m_rw;
  logic [4:0]  m_wr;
  logic [31:0] m_wd, m_cnt;

  mem_wb_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .LINK_REG(31)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .memValid(memValid), .memRegWrite(memRegWrite), .memMemToReg(memMemToReg),
    .memLink(memLink), .memWriteReg(memWriteReg), .memAluResult(memAluResult),
    .memReadData(memReadData), .memPcPlus4(memPcPlus4),
    .wbValid(wbValid), .wbRegWrite(wbRegWrite), .wbWriteReg(wbWriteReg),
    .wbWriteData(wbWriteData), .retireCount(retireCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what one rising edge must do, straight from the stage rules.
  always @(posedge clk) begin : model
    logic [4:0]  dest;
    logic [31:0] cnt;
    cnt = preload ? 32'hFFFF_FFFF : m_cnt;
    dest = memLink ? 5'd31 : memWriteReg;
    if (reset) begin
      m_valid <= 0; m_rw <= 0; m_wr <= 0; m_wd <= 0; m_cnt <= 0;
    end else if (flush) begin
      m_valid <= 0; m_rw <= 0; m_wr <= 0; m_wd <= 0; m_cnt <= cnt;
    end else if (stall) begin
      m_cnt <= cnt;
    end else begin
      m_valid <= memValid;
      m_wr    <= dest;
      m_wd    <= memLink ? memPcPlus4 : (memMemToReg ? memReadData : memAluResult);
      m_rw    <= memValid && (memRegWrite || memLink) && (dest != 5'd0);
      m_cnt   <= memValid ? cnt + 32'd1 : cnt;
    end
  end

  // Compare process: every falling edge once the model is defined.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("valid", 32'(wbValid), 32'(m_valid));
      chk("regwrite", 32'(wbRegWrite), 32'(m_rw));
      chk("writereg", 32'(wbWriteReg), 32'(m_wr));
      chk("writedata", wbWriteData, m_wd);
      chk("retire", retireCount, m_cnt);
    end
  end

  task automatic drive(input bit rst, input bit fl, input bit st, input bit v,
                       input bit rw, input bit m2r, input bit lk, input logic [4:0] wr,
                       input logic [31:0] alu, input logic [31:0] rd, input logic [31:0] pc);
    reset = rst; flush = fl; stall = st; memValid = v; memRegWrite = rw;
    memMemToReg = m2r; memLink = lk; memWriteReg = wr;
    memAluResult = alu; memReadData = rd; memPcPlus4 = pc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_rand(input bit rst, input bit fl, input bit st);
    drive(rst, fl, st, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 5) == 0),
          ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom, $urandom, $urandom);
  endtask

  task automatic lit_all(input string tag, input logic v, input logic rw,
                         input logic [4:0] wr, input logic [31:0] wd, input logic [31:0] cnt);
    chk({tag, "_valid"}, 32'(wbValid), 32'(v));
    chk({tag, "_regwrite"}, 32'(wbRegWrite), 32'(rw));
    chk({tag, "_writereg"}, 32'(wbWriteReg), 32'(wr));
    chk({tag, "_writedata"}, wbWriteData, wd);
    chk({tag, "_retire"}, retireCount, cnt);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
    cmp_en = 1;
    drive(1, 0, 0, 1, 1, 0, 0, 5'd7, 32'h1234, 32'h0, 32'h0);
    lit_all("reset", 0, 0, 5'd0, 32'd0, 32'd0);

    drive(0, 0, 0, 1, 1, 0, 0, 5'd8, 32'h0000_0005, 32'h0, 32'h0);
    lit_all("add", 1, 1, 5'd8, 32'd5, 32'd1);
    drive(0, 0, 0, 1, 1, 1, 0, 5'd9, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0);
    lit_all("load", 1, 1, 5'd9, 32'hDEAD_BEEF, 32'd2);
    drive(0, 0, 0, 1, 0, 1, 1, 5'd0, 32'h1111, 32'h2222, 32'h0040_0010);
    lit_all("jal", 1, 1, 5'd31, 32'h0040_0010, 32'd3);
    drive(0, 0, 0, 1, 1, 0, 0, 5'd0, 32'hAB, 32'h0, 32'h0);
    lit_all("zero", 1, 0, 5'd0, 32'hAB, 32'd4);
    drive(0, 0, 0, 0, 1, 0, 0, 5'd12, 32'hCD, 32'h0, 32'h0);
    lit_all("invalid", 0, 0, 5'd12, 32'hCD, 32'd4);

    drive(0, 0, 0, 1, 0, 0, 1, 5'd3, 32'h0, 32'h0, 32'h0040_0100);
    for (int i = 0; i < 3; i++) drive_rand(0, 0, 1);
    lit_all("stall", 1, 1, 5'd31, 32'h0040_0100, 32'd5);
    drive(0, 1, 1, 1, 1, 0, 0, 5'd4, 32'h77, 32'h0, 32'h0);
    lit_all("flushstall", 0, 0, 5'd0, 32'd0, 32'd5);
    drive(1, 1, 1, 1, 1, 0, 0, 5'd4, 32'h77, 32'h0, 32'h0);
    lit_all("resetflush", 0, 0, 5'd0, 32'd0, 32'd0);

    // retire counter wrap: preload all-ones then retire one instruction
    #2;
    force dut.r_retire_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_retire_count;
    preload = 1;
    drive(0, 0, 0, 1, 1, 0, 0, 5'd5, 32'h9, 32'h0, 32'h0);
    preload = 0;
    lit_all("wrap", 1, 1, 5'd5, 32'h9, 32'd0);

    for (int i = 0; i < 400; i++) begin
      drive_rand($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0);
    end

    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
